// File: rtl/dmem_responder.sv
// Word-addressed data memory behind a req/ack handshake with LATENCY wait states.
// Requests are captured in IDLE, counted down in WAIT and answered with a one-cycle ack in RESP.
module dmem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        ack,
    output logic        err,
    output logic [31:0] rdata,
    output logic        busy
);

    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        ack_q, ack_d;
    logic        err_q, err_d;
    logic [31:0] rdata_q, rdata_d;
    logic        busy_q, busy_d;

    logic [31:0]   mem [DEPTH_WORDS];
    logic          legal;
    logic          memWrite;
    logic [AW-1:0] wordIdx;

    // Out-of-range word indices are errors rather than aliases, so compare the full upper address.
    assign wordIdx = addr_q[AW+1:2];
    assign legal   = (addr_q[1:0] == 2'b00) && ({2'b00, addr_q[31:2]} < 32'(DEPTH_WORDS));

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        ack_d    = 1'b0;
        err_d    = 1'b0;
        rdata_d  = rdata_q;
        busy_d   = busy_q;
        memWrite = 1'b0;
        case (state_q)
            IDLE: begin
                if (req) begin
                    we_d    = we;
                    addr_d  = addr;
                    wdata_d = wdata;
                    cnt_d   = 4'(LATENCY);
                    state_d = WAIT;
                    busy_d  = 1'b1;
                end
            end
            WAIT: begin
                busy_d = 1'b1;
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d = RESP;
                    ack_d   = 1'b1;
                    if (!legal) begin
                        err_d   = 1'b1;
                        rdata_d = 32'h0;
                    end else if (we_q) begin
                        memWrite = 1'b1;
                    end else begin
                        rdata_d = mem[wordIdx];
                    end
                end
            end
            RESP: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= 32'h0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
            busy_q  <= busy_d;
        end
    end

    // The array is never cleared; reset only blocks a write that would complete on the same edge.
    always_ff @(posedge clock) begin
        if (memWrite && !reset) begin
            mem[wordIdx] <= wdata_q;
        end
    end

    assign ack   = ack_q;
    assign err   = err_q;
    assign rdata = rdata_q;
    assign busy  = busy_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder: a LATENCY=2 instance for protocol and error
// cases, and a LATENCY=0 instance for back-to-back store/load traffic.
module tb_dmem_responder;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        reqS  = 1'b0;
    logic        reqF  = 1'b0;
    logic        we    = 1'b0;
    logic [31:0] addr  = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic        ackS, errS, busyS;
    logic        ackF, errF, busyF;
    logic [31:0] rdS, rdF;

    int errors = 0;
    int checks = 0;

    logic [31:0] rd;
    logic        er;
    int          lat;

    dmem_responder #(.DEPTH_WORDS(256), .LATENCY(2)) u_slow (
        .clock(clock), .reset(reset), .req(reqS), .we(we), .addr(addr), .wdata(wdata),
        .ack(ackS), .err(errS), .rdata(rdS), .busy(busyS)
    );

    dmem_responder #(.DEPTH_WORDS(256), .LATENCY(0)) u_fast (
        .clock(clock), .reset(reset), .req(reqF), .we(we), .addr(addr), .wdata(wdata),
        .ack(ackF), .err(errF), .rdata(rdF), .busy(busyF)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic checkBit(input string tag, input logic observed, input logic expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%b expected=%b", tag, observed, expected);
        end
    endtask

    // Raises req and waits (bounded) for ack; lat counts edges from req assertion to the ack cycle.
    task automatic applyStimulus(input bit fast, input logic weV, input logic [31:0] a,
                                 input logic [31:0] wd, output logic [31:0] rdo,
                                 output logic ero, output int lato);
        logic seen;
        we    = weV;
        addr  = a;
        wdata = wd;
        if (fast) reqF = 1'b1;
        else      reqS = 1'b1;
        lato = 0;
        seen = 1'b0;
        while (!seen && lato < 20) begin
            tick();
            lato++;
            seen = fast ? ackF : ackS;
        end
        rdo  = fast ? rdF : rdS;
        ero  = fast ? errF : errS;
        reqS = 1'b0;
        reqF = 1'b0;
    endtask

    task automatic finishAccess(input bit fast, input string tag);
        tick();
        checkBit({tag, "_ackWidth"}, fast ? ackF : ackS, 1'b0);
        checkBit({tag, "_idle"}, fast ? busyF : busyS, 1'b0);
    endtask

    initial begin
        $display("[TB] starting");

        reset = 1'b1;
        reqS  = 1'b1;
        reqF  = 1'b1;
        we    = 1'b1;
        addr  = 32'h10;
        wdata = 32'hFFFF_FFFF;
        tick();
        tick();
        checkBit("rst_ack", ackS, 1'b0);
        checkBit("rst_err", errS, 1'b0);
        checkOutput("rst_rdata", rdS, 32'h0);
        checkBit("rst_busy", busyS, 1'b0);
        checkBit("rst_busyFast", busyF, 1'b0);
        reset = 1'b0;
        reqS  = 1'b0;
        reqF  = 1'b0;
        tick();
        checkBit("rst_noCapture", busyS, 1'b0);

        applyStimulus(1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, rd, er, lat);
        checkOutput("st10_lat", 32'(lat), 32'd4);
        checkBit("st10_err", er, 1'b0);
        finishAccess(1'b0, "st10");

        applyStimulus(1'b0, 1'b0, 32'h10, 32'h0, rd, er, lat);
        checkOutput("ld10_lat", 32'(lat), 32'd4);
        checkOutput("ld10_data", rd, 32'hDEAD_BEEF);
        checkBit("ld10_err", er, 1'b0);
        finishAccess(1'b0, "ld10");

        applyStimulus(1'b0, 1'b1, 32'h40, 32'h0000_0055, rd, er, lat);
        checkOutput("st40_rdataHeld", rd, 32'hDEAD_BEEF);
        checkBit("st40_err", er, 1'b0);
        finishAccess(1'b0, "st40");

        applyStimulus(1'b0, 1'b1, 32'h11, 32'h0BAD_0BAD, rd, er, lat);
        checkBit("st11_err", er, 1'b1);
        checkOutput("st11_rdata", rd, 32'h0);
        finishAccess(1'b0, "st11");

        applyStimulus(1'b0, 1'b0, 32'h10, 32'h0, rd, er, lat);
        checkOutput("ld10b_data", rd, 32'hDEAD_BEEF);
        checkBit("ld10b_err", er, 1'b0);
        finishAccess(1'b0, "ld10b");

        applyStimulus(1'b0, 1'b0, 32'h400, 32'h0, rd, er, lat);
        checkBit("ld400_err", er, 1'b1);
        checkOutput("ld400_rdata", rd, 32'h0);
        finishAccess(1'b0, "ld400");

        applyStimulus(1'b0, 1'b0, 32'h40, 32'h0, rd, er, lat);
        checkOutput("ld40_data", rd, 32'h0000_0055);
        finishAccess(1'b0, "ld40");

        // Inputs wiggle during WAIT and req stays high through RESP.
        applyStimulus(1'b0, 1'b1, 32'h34, 32'h3333_4444, rd, er, lat);
        finishAccess(1'b0, "st34");
        we    = 1'b1;
        addr  = 32'h30;
        wdata = 32'h1111_2222;
        reqS  = 1'b1;
        tick();
        checkBit("hold_busy", busyS, 1'b1);
        we    = 1'b0;
        addr  = 32'h34;
        wdata = 32'h0;
        tick();
        tick();
        tick();
        checkBit("hold_ack", ackS, 1'b1);
        checkBit("hold_err", errS, 1'b0);
        tick();
        checkBit("hold_ackWidth", ackS, 1'b0);
        checkBit("hold_noRecapture", busyS, 1'b0);
        reqS = 1'b0;
        tick();
        checkBit("hold_stillIdle", busyS, 1'b0);

        applyStimulus(1'b0, 1'b0, 32'h30, 32'h0, rd, er, lat);
        checkOutput("ld30_data", rd, 32'h1111_2222);
        finishAccess(1'b0, "ld30");
        applyStimulus(1'b0, 1'b0, 32'h34, 32'h0, rd, er, lat);
        checkOutput("ld34_data", rd, 32'h3333_4444);
        finishAccess(1'b0, "ld34");

        // Reset lands exactly on the edge that would have committed the store.
        applyStimulus(1'b0, 1'b1, 32'h20, 32'hA5A5_A5A5, rd, er, lat);
        finishAccess(1'b0, "st20pre");
        we    = 1'b1;
        addr  = 32'h20;
        wdata = 32'h1234_5678;
        reqS  = 1'b1;
        tick();
        reqS = 1'b0;
        tick();
        tick();
        checkBit("midrst_busyBefore", busyS, 1'b1);
        checkBit("midrst_ackBefore", ackS, 1'b0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checkBit("midrst_ack", ackS, 1'b0);
        checkBit("midrst_busy", busyS, 1'b0);
        tick();
        checkBit("midrst_noLateAck", ackS, 1'b0);
        applyStimulus(1'b0, 1'b0, 32'h20, 32'h0, rd, er, lat);
        checkOutput("ld20_data", rd, 32'hA5A5_A5A5);
        checkBit("ld20_err", er, 1'b0);
        finishAccess(1'b0, "ld20");

        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b1, 1'b1, 32'(i * 4), 32'hC0DE_0000 | 32'(i), rd, er, lat);
            checkOutput("fastSt_lat", 32'(lat), 32'd2);
            checkBit("fastSt_err", er, 1'b0);
            finishAccess(1'b1, "fastSt");
            applyStimulus(1'b1, 1'b0, 32'(i * 4), 32'h0, rd, er, lat);
            checkOutput("fastLd_lat", 32'(lat), 32'd2);
            checkOutput("fastLd_data", rd, 32'hC0DE_0000 | 32'(i));
            finishAccess(1'b1, "fastLd");
        end
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b1, 1'b0, 32'(i * 4), 32'h0, rd, er, lat);
            checkOutput("fastReread", rd, 32'hC0DE_0000 | 32'(i));
            finishAccess(1'b1, "fastReread");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
